// File: rtl/debounced_comparator.sv
// -----------------------------------------------------------------------------
// debounced_comparator
//
// Registered, debounced magnitude comparator for two DIP-switch operands.
// Each operand is synchronised (2 flops) and then filtered by its own debounce
// counter, so switch bounce never reaches the status outputs. The debounced
// operands are compared as unsigned or two's-complement values, selected at
// run time by signed_mode (synchronised only, not debounced).
//
// After reset the block spends DEBOUNCE_CYCLES cycles in INIT, then captures
// the synchronised operands directly as the initial stable values and moves
// to RUN, where the compare result is registered every cycle.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   a_raw        operand a straight from the switches (asynchronous)
//   b_raw        operand b straight from the switches (asynchronous)
//   signed_mode  0 = unsigned compare, 1 = signed compare (asynchronous)
//   lt/eq/gt     registered compare of debounced a against debounced b
//   valid        high once the initial operands have been captured
//   changed      one-cycle pulse when {lt,eq,gt} changes while valid
// -----------------------------------------------------------------------------
module debounced_comparator #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_raw,
    input  logic [WIDTH-1:0] b_raw,
    input  logic             signed_mode,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             valid,
    output logic             changed
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]     a_sync1, a_sync2, a_sync2_q;
    logic [WIDTH-1:0]     b_sync1, b_sync2, b_sync2_q;
    logic                 mode_sync1, mode_sync2;
    logic [WIDTH-1:0]     stable_a, stable_b;
    logic [CNT_WIDTH-1:0] cnt_a, cnt_b;
    logic [CNT_WIDTH-1:0] init_cnt;
    logic                 init_done;
    logic                 lt_next, eq_next, gt_next;

    // -------------------------------------------------------------------------
    // Synchronisers plus a one-cycle delayed copy of each operand, used by the
    // debounce filter to detect that the synchronised value just moved.
    // -------------------------------------------------------------------------
    // NOTE: every flop here uses non-blocking assignments so that sync1 ->
    // sync2 -> sync2_q behaves as a real shift chain regardless of statement
    // order; blocking assignments would collapse the chain into one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync1    <= '0;
            a_sync2    <= '0;
            a_sync2_q  <= '0;
            b_sync1    <= '0;
            b_sync2    <= '0;
            b_sync2_q  <= '0;
            mode_sync1 <= 1'b0;
            mode_sync2 <= 1'b0;
        end else begin
            a_sync1    <= a_raw;
            a_sync2    <= a_sync1;
            a_sync2_q  <= a_sync2;
            b_sync1    <= b_raw;
            b_sync2    <= b_sync1;
            b_sync2_q  <= b_sync2;
            mode_sync1 <= signed_mode;
            mode_sync2 <= mode_sync1;
        end
    end

    // -------------------------------------------------------------------------
    // INIT / RUN control. INIT lasts until the shared counter reaches D-1; RUN
    // is only left through reset.
    // -------------------------------------------------------------------------
    assign init_done = (state == ST_INIT) && (init_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: next-state logic assigns its default before any branch so that
    // every path drives state_next and no latch is inferred.
    always_comb begin
        state_next = state;
        if (init_done) begin
            state_next = ST_RUN;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce filters. A candidate value is accepted only after it has been
    // present in sync2, unchanged and different from stable, for D consecutive
    // checks. Any movement of sync2, or a return to the stable value, restarts
    // the count. During INIT the filters are held cleared and stable is loaded
    // directly when INIT completes.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_a <= '0;
            cnt_a    <= '0;
        end else if (state == ST_INIT) begin
            cnt_a <= '0;
            if (init_done) begin
                stable_a <= a_sync2;
            end
        end else if ((a_sync2 == stable_a) || (a_sync2 != a_sync2_q)) begin
            cnt_a <= '0;
        end else if (cnt_a == CNT_LAST) begin
            stable_a <= a_sync2;
            cnt_a    <= '0;
        end else begin
            cnt_a <= cnt_a + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_b <= '0;
            cnt_b    <= '0;
        end else if (state == ST_INIT) begin
            cnt_b <= '0;
            if (init_done) begin
                stable_b <= b_sync2;
            end
        end else if ((b_sync2 == stable_b) || (b_sync2 != b_sync2_q)) begin
            cnt_b <= '0;
        end else if (cnt_b == CNT_LAST) begin
            stable_b <= b_sync2;
            cnt_b    <= '0;
        end else begin
            cnt_b <= cnt_b + CNT_WIDTH'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Compare stage. Both interpretations stay at WIDTH bits; in signed mode
    // the MSB is the sign bit of each operand.
    // -------------------------------------------------------------------------
    always_comb begin
        lt_next = 1'b0;
        if (mode_sync2) begin
            lt_next = $signed(stable_a) < $signed(stable_b);
        end else begin
            lt_next = stable_a < stable_b;
        end
        eq_next = (stable_a == stable_b);
        gt_next = !lt_next && !eq_next;
    end

    // changed compares against the previously registered result and is gated
    // by the previous valid, so the first result after INIT never pulses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            valid   <= 1'b0;
            changed <= 1'b0;
        end else if (state == ST_RUN) begin
            lt      <= lt_next;
            eq      <= eq_next;
            gt      <= gt_next;
            valid   <= 1'b1;
            changed <= valid && ({lt, eq, gt} != {lt_next, eq_next, gt_next});
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debounced_comparator.sv
// -----------------------------------------------------------------------------
// tb_debounced_comparator
//
// Directed bench for debounced_comparator with WIDTH=4, DEBOUNCE_CYCLES=4.
// Expected values are hand-derived; outputs are sampled 1 ns after each rising
// edge and packed as {valid, lt, eq, gt, changed}.
// -----------------------------------------------------------------------------
module tb_debounced_comparator;

    localparam int WIDTH = 4;
    localparam int D     = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_raw;
    logic             signed_mode;
    logic             lt, eq, gt, valid, changed;

    int checks   = 0;
    int failures = 0;

    debounced_comparator #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_raw      (a_raw),
        .b_raw      (b_raw),
        .signed_mode(signed_mode),
        .lt         (lt),
        .eq         (eq),
        .gt         (gt),
        .valid      (valid),
        .changed    (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output patterns {valid, lt, eq, gt, changed}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_LT   = 5'b11000;
    localparam logic [4:0] O_EQ   = 5'b10100;
    localparam logic [4:0] O_GT   = 5'b10010;
    localparam logic [4:0] O_LT_C = 5'b11001;
    localparam logic [4:0] O_EQ_C = 5'b10101;

    function automatic logic [4:0] obs();
        return {valid, lt, eq, gt, changed};
    endfunction

    // One rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_and_init();
        rst = 1'b1; a_raw = 4'd3; b_raw = 4'd5; signed_mode = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if (obs() !== O_IDLE) begin
                failures++;
                $display("FAIL init_edge%0d: got %b expected %b", e, obs(), O_IDLE);
            end
        end
        step();
        checks++;
        if (obs() !== O_LT) begin
            failures++;
            $display("FAIL init_first_valid: got %b expected %b", obs(), O_LT);
        end
    endtask

    task automatic test_debounced_update();
        a_raw = 4'd5;
        for (int e = 0; e <= 6; e++) begin
            step();
            checks++;
            if (obs() !== O_LT) begin
                failures++;
                $display("FAIL update_hold_edge%0d: got %b expected %b", e, obs(), O_LT);
            end
        end
        step();
        checks++;
        if (obs() !== O_EQ_C) begin
            failures++;
            $display("FAIL update_edge7: got %b expected %b", obs(), O_EQ_C);
        end
        step();
        checks++;
        if (obs() !== O_EQ) begin
            failures++;
            $display("FAIL update_pulse_end: got %b expected %b", obs(), O_EQ);
        end
    endtask

    task automatic test_bounce();
        a_raw = 4'd3;
        repeat (10) step();
        checks++;
        if (obs() !== O_LT) begin
            failures++;
            $display("FAIL bounce_setup: got %b expected %b", obs(), O_LT);
        end
        // 3 <-> 6 every 2 cycles for 12 cycles, ending on 3
        for (int i = 0; i < 6; i++) begin
            a_raw = (i % 2 == 0) ? 4'd6 : 4'd3;
            repeat (2) begin
                step();
                checks++;
                if (obs() !== O_LT) begin
                    failures++;
                    $display("FAIL bounce_toggle%0d: got %b expected %b", i, obs(), O_LT);
                end
            end
        end
        // A glitch held for D cycles is still one short of acceptance
        a_raw = 4'd6;
        repeat (D) step();
        a_raw = 4'd3;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (obs() !== O_LT) begin
                failures++;
                $display("FAIL bounce_settle%0d: got %b expected %b", e, obs(), O_LT);
            end
        end
    endtask

    task automatic test_signed_mode();
        a_raw = 4'hF; b_raw = 4'h1; signed_mode = 1'b0;
        repeat (10) step();
        checks++;
        if (obs() !== O_GT) begin
            failures++;
            $display("FAIL signed_unsigned_gt: got %b expected %b", obs(), O_GT);
        end
        signed_mode = 1'b1;
        for (int e = 0; e <= 1; e++) begin
            step();
            checks++;
            if (obs() !== O_GT) begin
                failures++;
                $display("FAIL signed_latency_edge%0d: got %b expected %b", e, obs(), O_GT);
            end
        end
        step();
        checks++;
        if (obs() !== O_LT_C) begin
            failures++;
            $display("FAIL signed_edge2: got %b expected %b", obs(), O_LT_C);
        end
        step();
        checks++;
        if (obs() !== O_LT) begin
            failures++;
            $display("FAIL signed_pulse_end: got %b expected %b", obs(), O_LT);
        end
    endtask

    task automatic test_reset_mid_debounce();
        // signed: 4'hF (-1) < 1 now; 2 > 1 in either mode after re-init
        a_raw = 4'd2;
        repeat (3) step();
        checks++;
        if (obs() !== O_LT) begin
            failures++;
            $display("FAIL midrst_before: got %b expected %b", obs(), O_LT);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs() !== O_IDLE) begin
            failures++;
            $display("FAIL midrst_cleared: got %b expected %b", obs(), O_IDLE);
        end
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if (obs() !== O_IDLE) begin
                failures++;
                $display("FAIL midrst_init_edge%0d: got %b expected %b", e, obs(), O_IDLE);
            end
        end
        step();
        checks++;
        if (obs() !== O_GT) begin
            failures++;
            $display("FAIL midrst_revalid: got %b expected %b", obs(), O_GT);
        end
    endtask

    task automatic test_back_to_back();
        a_raw = 4'd2; b_raw = 4'd4; signed_mode = 1'b0;
        repeat (10) step();
        checks++;
        if (obs() !== O_LT) begin
            failures++;
            $display("FAIL b2b_setup: got %b expected %b", obs(), O_LT);
        end
        a_raw = 4'd7; b_raw = 4'd9;
        for (int e = 0; e <= 9; e++) begin
            step();
            checks++;
            if (obs() !== O_LT) begin
                failures++;
                $display("FAIL b2b_edge%0d: got %b expected %b", e, obs(), O_LT);
            end
            if (e == D + 1) begin
                checks++;
                if ({dut.stable_a, dut.stable_b} !== 8'h24) begin
                    failures++;
                    $display("FAIL b2b_stable_before: got %h expected 24",
                             {dut.stable_a, dut.stable_b});
                end
            end
            if (e == D + 2) begin
                checks++;
                if ({dut.stable_a, dut.stable_b} !== 8'h79) begin
                    failures++;
                    $display("FAIL b2b_stable_after: got %h expected 79",
                             {dut.stable_a, dut.stable_b});
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; a_raw = '0; b_raw = '0; signed_mode = 1'b0;
        test_reset_and_init();
        test_debounced_update();
        test_bounce();
        test_signed_mode();
        test_reset_mid_debounce();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
